multi_cycle_controller: RTL and testbench

- Moore/Mealy FSM that sequences a multi-cycle RV32I datapath (shared ALU, single unified memory, IR/MDR/ALUOut registers).
- Supported instructions: LW, SW, BEQ, R-type, I-type arithmetic, JAL, JALR.
- Replaces the single-cycle opcode decoder in the multi-cycle CPU variant.
- Handles memory accesses of variable latency through a req/ready handshake.

---
 rtl/multi_cycle_controller.sv | 182 ++++++++++++++++++
 tb/tb_multi_cycle_controller.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_controller.sv
// rtl/multi_cycle_controller.sv - multi-cycle RV32I control FSM with req/ready memory handshake
// Optional MC_CTRL_ILLEGAL_TRAP_EN: unknown opcodes trap into a sticky HALT state.
module multi_cycle_controller #(
  parameter int RESET_TO_IDLE = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] instr_op_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       IorD_o,
  output logic       MemRead_o,
  output logic       MemWrite_o,
  output logic       IRWrite_o,
  output logic       PCWrite_o,
  output logic       PCWriteCond_o,
  output logic [1:0] PCSource_o,
  output logic [1:0] ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output logic [1:0] ALUop_o,
  output logic       RegWrite_o,
  output logic [1:0] MemtoReg_o,
  output logic [3:0] state_o,
  output logic       illegal_o
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2,  S_EXEC   = 4'd3,
    S_ADDR   = 4'd4,  S_MEM_RD = 4'd5,  S_MEM_WR = 4'd6,  S_WB_ALU = 4'd7,
    S_WB_MEM = 4'd8,  S_BRANCH = 4'd9,  S_JAL    = 4'd10, S_JALR   = 4'd11,
    S_HALT   = 4'd12
  } state_e;

  localparam state_e RESET_STATE = (RESET_TO_IDLE != 0) ? S_IDLE : S_FETCH;

  state_e     state_q, state_d;
  logic [4:0] opc;
  logic       unused_op_bits;

  assign opc            = instr_op_i[6:2];
  assign unused_op_bits = ^instr_op_i[1:0];
  assign state_o        = state_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= RESET_STATE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    mem_req_o     = 1'b0;
    IorD_o        = 1'b0;
    MemRead_o     = 1'b0;
    MemWrite_o    = 1'b0;
    IRWrite_o     = 1'b0;
    PCWrite_o     = 1'b0;
    PCWriteCond_o = 1'b0;
    PCSource_o    = 2'b00;
    ALUSrcA_o     = 2'b00;
    ALUSrcB_o     = 2'b00;
    ALUop_o       = 2'b00;
    RegWrite_o    = 1'b0;
    MemtoReg_o    = 2'b00;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_req_o = 1'b1;
        MemRead_o = 1'b1;
        ALUSrcB_o = 2'b01;
        if (mem_ready_i) begin
          IRWrite_o = 1'b1;
          PCWrite_o = 1'b1;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALUOut captures oldPC + imm here so BRANCH/JAL can use it as target
        ALUSrcA_o = 2'b10;
        ALUSrcB_o = 2'b10;
        case (opc)
          5'b00000, 5'b01000: state_d = S_ADDR;
          5'b01100, 5'b00100: state_d = S_EXEC;
          5'b11000:           state_d = S_BRANCH;
          5'b11011:           state_d = S_JAL;
          5'b11001:           state_d = S_JALR;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          default:            state_d = S_HALT;
`else
          default:            state_d = S_FETCH;
`endif
        endcase
      end
      S_ADDR: begin
        ALUSrcA_o = 2'b01;
        ALUSrcB_o = 2'b10;
        state_d   = opc[3] ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req_o = 1'b1;
        MemRead_o = 1'b1;
        IorD_o    = 1'b1;
        if (mem_ready_i) state_d = S_WB_MEM;
      end
      S_MEM_WR: begin
        mem_req_o  = 1'b1;
        MemWrite_o = 1'b1;
        IorD_o     = 1'b1;
        if (mem_ready_i) state_d = S_FETCH;
      end
      S_WB_MEM: begin
        RegWrite_o = 1'b1;
        MemtoReg_o = 2'b01;
        state_d    = S_FETCH;
      end
      S_EXEC: begin
        ALUSrcA_o = 2'b01;
        ALUSrcB_o = opc[3] ? 2'b00 : 2'b10;
        ALUop_o   = 2'b10;
        state_d   = S_WB_ALU;
      end
      S_WB_ALU: begin
        RegWrite_o = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA_o     = 2'b01;
        ALUop_o       = 2'b01;
        PCWriteCond_o = 1'b1;
        PCSource_o    = 2'b01;
        state_d       = S_FETCH;
      end
      S_JAL: begin
        RegWrite_o = 1'b1;
        MemtoReg_o = 2'b10;
        PCWrite_o  = 1'b1;
        PCSource_o = 2'b01;
        state_d    = S_FETCH;
      end
      S_JALR: begin
        RegWrite_o = 1'b1;
        MemtoReg_o = 2'b10;
        ALUSrcA_o  = 2'b01;
        ALUSrcB_o  = 2'b10;
        PCWrite_o  = 1'b1;
        PCSource_o = 2'b10;
        state_d    = S_FETCH;
      end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      S_HALT:  state_d = S_HALT;
`endif
      default: state_d = S_FETCH;
    endcase
    // Reset must silence every request and write enable even if the reset state is FETCH
    if (!rst_i) begin
      mem_req_o     = 1'b0;
      MemRead_o     = 1'b0;
      MemWrite_o    = 1'b0;
      IorD_o        = 1'b0;
      IRWrite_o     = 1'b0;
      PCWrite_o     = 1'b0;
      PCWriteCond_o = 1'b0;
      PCSource_o    = 2'b00;
      ALUSrcA_o     = 2'b00;
      ALUSrcB_o     = 2'b00;
      ALUop_o       = 2'b00;
      RegWrite_o    = 1'b0;
      MemtoReg_o    = 2'b00;
    end
  end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                 illegal_q <= 1'b0;
    else if (state_d == S_HALT) illegal_q <= 1'b1;
  end
  assign illegal_o = illegal_q;
`else
  assign illegal_o = 1'b0;
`endif

endmodule

// File: tb/tb_multi_cycle_controller.sv
// tb/tb_multi_cycle_controller.sv - directed table-driven bench for multi_cycle_controller
module tb_multi_cycle_controller;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [6:0]  op;
  logic        rdy;
  logic        mem_req_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o, PCWrite_o, PCWriteCond_o;
  logic [1:0]  PCSource_o, ALUSrcA_o, ALUSrcB_o, ALUop_o, MemtoReg_o;
  logic        RegWrite_o, illegal_o;
  logic [3:0]  state_o;
  logic [17:0] ctl0;
  logic [3:0]  state0;
  logic        illegal0;

  always #5 clk_i = ~clk_i;

  multi_cycle_controller #(.RESET_TO_IDLE(1)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .instr_op_i(op), .mem_ready_i(rdy),
    .mem_req_o(mem_req_o), .IorD_o(IorD_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
    .IRWrite_o(IRWrite_o), .PCWrite_o(PCWrite_o), .PCWriteCond_o(PCWriteCond_o),
    .PCSource_o(PCSource_o), .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o), .ALUop_o(ALUop_o),
    .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .state_o(state_o), .illegal_o(illegal_o)
  );

  multi_cycle_controller #(.RESET_TO_IDLE(0)) u_dut0 (
    .clk_i(clk_i), .rst_i(rst_i), .instr_op_i(op), .mem_ready_i(rdy),
    .mem_req_o(ctl0[17]), .IorD_o(ctl0[16]), .MemRead_o(ctl0[15]), .MemWrite_o(ctl0[14]),
    .IRWrite_o(ctl0[13]), .PCWrite_o(ctl0[12]), .PCWriteCond_o(ctl0[11]),
    .PCSource_o(ctl0[10:9]), .ALUSrcA_o(ctl0[8:7]), .ALUSrcB_o(ctl0[6:5]), .ALUop_o(ctl0[4:3]),
    .RegWrite_o(ctl0[2]), .MemtoReg_o(ctl0[1:0]), .state_o(state0), .illegal_o(illegal0)
  );

  typedef struct {
    logic [6:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [17:0] ctl;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   pulses;

  logic [17:0] C_ZERO, C_FW, C_FG, C_DEC, C_ADDR, C_MRD, C_MWR, C_WBM;
  logic [17:0] C_EXR, C_EXI, C_WBA, C_BR, C_JAL, C_JALR;
  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011, OP_BEQ = 7'b1100011, OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111, OP_BAD = 7'b1111111;

  function automatic logic [17:0] ctl(input logic req, iord, mr, mw, irw, pcw, pcc,
                                      input logic [1:0] pcs, asa, asb, aop,
                                      input logic rw, input logic [1:0] m2r);
    return {req, iord, mr, mw, irw, pcw, pcc, pcs, asa, asb, aop, rw, m2r};
  endfunction

  function automatic logic [17:0] dut_ctl();
    return {mem_req_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o, PCWrite_o, PCWriteCond_o,
            PCSource_o, ALUSrcA_o, ALUSrcB_o, ALUop_o, RegWrite_o, MemtoReg_o};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [6:0] o, input logic r, input logic [3:0] s, input logic [17:0] c);
    vec_t v;
    v.op = o; v.rdy = r; v.st = s; v.ctl = c;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b0; op = '0; rdy = 1'b0;
    C_ZERO = '0;
    C_FW   = ctl(1,0,1,0,0,0,0, 2'b00, 2'b00, 2'b01, 2'b00, 0, 2'b00);
    C_FG   = ctl(1,0,1,0,1,1,0, 2'b00, 2'b00, 2'b01, 2'b00, 0, 2'b00);
    C_DEC  = ctl(0,0,0,0,0,0,0, 2'b00, 2'b10, 2'b10, 2'b00, 0, 2'b00);
    C_ADDR = ctl(0,0,0,0,0,0,0, 2'b00, 2'b01, 2'b10, 2'b00, 0, 2'b00);
    C_MRD  = ctl(1,1,1,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00);
    C_MWR  = ctl(1,1,0,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00);
    C_WBM  = ctl(0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 2'b01);
    C_EXR  = ctl(0,0,0,0,0,0,0, 2'b00, 2'b01, 2'b00, 2'b10, 0, 2'b00);
    C_EXI  = ctl(0,0,0,0,0,0,0, 2'b00, 2'b01, 2'b10, 2'b10, 0, 2'b00);
    C_WBA  = ctl(0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 2'b00);
    C_BR   = ctl(0,0,0,0,0,0,1, 2'b01, 2'b01, 2'b00, 2'b01, 0, 2'b00);
    C_JAL  = ctl(0,0,0,0,0,1,0, 2'b01, 2'b00, 2'b00, 2'b00, 1, 2'b10);
    C_JALR = ctl(0,0,0,0,0,1,0, 2'b10, 2'b01, 2'b10, 2'b00, 1, 2'b10);

    add(OP_LW, 0, 4'd0, C_ZERO);
    add(OP_LW, 0, 4'd1, C_FW);
    add(OP_LW, 1, 4'd1, C_FG);
    add(OP_LW, 1, 4'd2, C_DEC);
    add(OP_LW, 1, 4'd4, C_ADDR);
    add(OP_LW, 0, 4'd5, C_MRD);
    add(OP_LW, 1, 4'd5, C_MRD);
    add(OP_LW, 0, 4'd8, C_WBM);
    add(OP_SW, 1, 4'd1, C_FG);
    add(OP_SW, 0, 4'd2, C_DEC);
    add(OP_SW, 0, 4'd4, C_ADDR);
    add(OP_SW, 0, 4'd6, C_MWR);
    add(OP_SW, 1, 4'd6, C_MWR);
    add(OP_R, 1, 4'd1, C_FG);
    add(OP_R, 0, 4'd2, C_DEC);
    add(OP_R, 0, 4'd3, C_EXR);
    add(OP_R, 1, 4'd7, C_WBA);
    add(OP_I, 1, 4'd1, C_FG);
    add(OP_I, 0, 4'd2, C_DEC);
    add(OP_I, 0, 4'd3, C_EXI);
    add(OP_I, 0, 4'd7, C_WBA);
    add(OP_BEQ, 1, 4'd1, C_FG);
    add(OP_BEQ, 0, 4'd2, C_DEC);
    add(OP_BEQ, 1, 4'd9, C_BR);
    add(OP_JAL, 1, 4'd1, C_FG);
    add(OP_JAL, 0, 4'd2, C_DEC);
    add(OP_JAL, 0, 4'd10, C_JAL);
    add(OP_JALR, 1, 4'd1, C_FG);
    add(OP_JALR, 0, 4'd2, C_DEC);
    add(OP_JALR, 0, 4'd11, C_JALR);

    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("reset_state", {28'd0, state_o}, 32'd0);
    check("reset_ctl", {14'd0, dut_ctl()}, {14'd0, C_ZERO});
    check("reset_illegal", {31'd0, illegal_o}, 32'd0);
    check("reset_state_r0", {28'd0, state0}, 32'd1);
    check("reset_memreq_r0", {31'd0, ctl0[17]}, 32'd0);
    step();
    rst_i = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      op  = vecs[i].op;
      rdy = vecs[i].rdy;
      @(negedge clk_i);
      check($sformatf("vec%0d_state", i), {28'd0, state_o}, {28'd0, vecs[i].st});
      check($sformatf("vec%0d_ctl", i), {14'd0, dut_ctl()}, {14'd0, vecs[i].ctl});
      check($sformatf("vec%0d_illegal", i), {31'd0, illegal_o}, 32'd0);
      if (i == 0) check("r0_fetch_after_reset", {28'd0, state0}, 32'd1);
      step();
    end

    op = OP_SW;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      rdy = (c == 3);
      @(negedge clk_i);
      check($sformatf("fwait%0d_state", c), {28'd0, state_o}, 32'd1);
      check($sformatf("fwait%0d_req", c), {31'd0, mem_req_o}, 32'd1);
      check($sformatf("fwait%0d_irw", c), {31'd0, IRWrite_o}, {31'd0, c == 3});
      check($sformatf("fwait%0d_pcw", c), {31'd0, PCWrite_o}, {31'd0, c == 3});
      pulses += int'(IRWrite_o);
      step();
    end
    check("fwait_irw_pulses", pulses, 1);

    rdy = 1'b0;
    @(negedge clk_i); check("sw2_decode", {28'd0, state_o}, 32'd2); step();
    @(negedge clk_i); check("sw2_addr", {28'd0, state_o}, 32'd4); step();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      check($sformatf("mwr_wait%0d", c), {14'd0, dut_ctl()}, {14'd0, C_MWR});
      check($sformatf("mwr_state%0d", c), {28'd0, state_o}, 32'd6);
      step();
    end
    #1 rst_i = 1'b0;
    #1;
    check("abort_req", {31'd0, mem_req_o}, 32'd0);
    check("abort_memwrite", {31'd0, MemWrite_o}, 32'd0);
    check("abort_state", {28'd0, state_o}, 32'd0);
    step();
    rst_i = 1'b1;
    @(negedge clk_i); check("post_abort_idle", {28'd0, state_o}, 32'd0); step();
    @(negedge clk_i); check("post_abort_fetch", {28'd0, state_o}, 32'd1);

    op  = OP_BAD;
    rdy = 1'b1;
    step();
    rdy = 1'b0;
    @(negedge clk_i); check("bad_decode", {28'd0, state_o}, 32'd2); step();
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    for (int c = 0; c < 22; c++) begin
      rdy = c[0];
      @(negedge clk_i);
      check($sformatf("halt%0d_state", c), {28'd0, state_o}, 32'd12);
      check($sformatf("halt%0d_illegal", c), {31'd0, illegal_o}, 32'd1);
      check($sformatf("halt%0d_ctl", c), {14'd0, dut_ctl()}, {14'd0, C_ZERO});
      step();
    end
    rst_i = 1'b0;
    #1 check("halt_reset_illegal", {31'd0, illegal_o}, 32'd0);
    step();
    rst_i = 1'b1;
`else
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      check($sformatf("nop%0d_state", c), {28'd0, state_o}, 32'd1);
      check($sformatf("nop%0d_illegal", c), {31'd0, illegal_o}, 32'd0);
      step();
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
